// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: bus widths, wait-counter width,
// FSM state encoding and the address-window helper.
package wb_pkg;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;
    localparam int WB_CNTW = 4;   // holds WAIT_STATES up to 15

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } wb_state_t;

    // Unsigned wrap makes addresses below the base land out of range as well.
    function automatic logic wb_in_range(input logic [WB_AW-1:0] adr,
                                         input logic [WB_AW-1:0] base,
                                         input logic [WB_AW-1:0] span);
        return (adr - base) < span;
    endfunction

endpackage

// File: rtl/wb_slave_ram_if.sv
// Wishbone classic slave-side bus bundle; clock and reset stay outside.
interface wb_slave_ram_if;
    import wb_pkg::*;

    logic [WB_AW-1:0]   wbs_adr_i;
    logic [WB_DW-1:0]   wbs_dat_i;
    logic [WB_DW-1:0]   wbs_dat_o;
    logic               wbs_we_i;
    logic [WB_SELW-1:0] wbs_sel_i;
    logic               wbs_stb_i;
    logic               wbs_cyc_i;
    logic               wbs_ack_o;
    logic               wbs_err_o;

    modport master (
        output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o
    );

    modport slave (
        input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o
    );

endinterface

// File: rtl/wb_ram_core.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port that holds its value between reads.
module wb_ram_core
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_we,
    input  logic               i_re,
    input  logic [WB_SELW-1:0] i_sel,
    input  logic [AW-1:0]      i_addr,
    input  logic [WB_DW-1:0]   i_wdata,
    output logic [WB_DW-1:0]   o_rdata
);

    logic [WB_DW-1:0] r_mem [DEPTH_WORDS];
    logic [WB_DW-1:0] r_rdata;

    // NOTE: the array has no reset branch; contents must survive reset, and a reset would block RAM inference.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < WB_SELW; b++) begin
                if (i_sel[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_slave_ram.sv
// Wishbone classic slave in front of wb_ram_core: request latch, programmable
// wait states, one-cycle ack/err response and address-window check.
module wb_slave_ram
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    wb_slave_ram_if.slave wbs
);

    localparam int unsigned        AW   = $clog2(DEPTH_WORDS);
    localparam logic [WB_AW-1:0]   SPAN = DEPTH_WORDS * 4;
    localparam logic [WB_CNTW-1:0] WS   = WAIT_STATES[WB_CNTW-1:0];

    wb_state_t          r_state;
    logic [WB_CNTW-1:0] r_cnt;
    logic [AW-1:0]      r_idx;
    logic [WB_DW-1:0]   r_dat;
    logic               r_we;
    logic [WB_SELW-1:0] r_sel;
    logic               r_in_range;
    logic               r_ack;
    logic               r_err;
    logic               r_rd_zero;

    logic               w_req;
    logic               w_idle;
    logic               w_in_range_now;
    logic [AW-1:0]      w_idx;
    logic [WB_DW-1:0]   w_dat;
    logic               w_we;
    logic [WB_SELW-1:0] w_sel;
    logic               w_in_range;
    logic               w_fire;
    logic [WB_DW-1:0]   w_rdata;

    assign w_req          = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign w_idle         = (r_state == IDLE);
    assign w_in_range_now = wb_in_range(wbs.wbs_adr_i, BASE_ADDR, SPAN);

    // With zero wait states the response edge is the sampling edge, so the
    // RAM must see the live bus request rather than the latched copy.
    assign w_idx      = w_idle ? wbs.wbs_adr_i[AW+1:2] : r_idx;
    assign w_dat      = w_idle ? wbs.wbs_dat_i         : r_dat;
    assign w_we       = w_idle ? wbs.wbs_we_i          : r_we;
    assign w_sel      = w_idle ? wbs.wbs_sel_i         : r_sel;
    assign w_in_range = w_idle ? w_in_range_now        : r_in_range;

    // High on the edge that moves the FSM into RESP.
    assign w_fire = (w_idle && w_req && (WS == '0)) ||
                    ((r_state == WAIT) && wbs.wbs_cyc_i && (r_cnt == WB_CNTW'(1)));

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_dat      <= '0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_in_range <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rd_zero  <= 1'b0;
        end else begin
            r_ack <= w_fire & w_in_range;
            r_err <= w_fire & ~w_in_range;
            if (w_fire && !w_we) r_rd_zero <= ~w_in_range;

            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_idx      <= wbs.wbs_adr_i[AW+1:2];
                        r_dat      <= wbs.wbs_dat_i;
                        r_we       <= wbs.wbs_we_i;
                        r_sel      <= wbs.wbs_sel_i;
                        r_in_range <= w_in_range_now;
                        r_cnt      <= WS;
                        r_state    <= (WS == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!wbs.wbs_cyc_i) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - WB_CNTW'(1);
                        if (r_cnt == WB_CNTW'(1)) r_state <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                // NOTE: the unused encoding 2'b11 falls back to IDLE instead of locking up.
                default: r_state <= IDLE;
            endcase
        end
    end

    wb_ram_core #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_n_i),
        .i_we    (w_fire & w_we & w_in_range),
        .i_re    (w_fire & ~w_we & w_in_range),
        .i_sel   (w_sel),
        .i_addr  (w_idx),
        .i_wdata (w_dat),
        .o_rdata (w_rdata)
    );

    assign wbs.wbs_dat_o = r_rd_zero ? '0 : w_rdata;
    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_err_o = r_err;

endmodule

// File: tb/tb_wb_slave_ram.sv
// Directed bench for wb_slave_ram: three instances with WAIT_STATES 1, 3 and 0
// share one clock and reset; each is driven through its own bus interface.
module tb_wb_slave_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cyc  [3];
    logic        stb  [3];
    logic        we   [3];
    logic [31:0] adr  [3];
    logic [31:0] wdat [3];
    logic [3:0]  sel  [3];
    logic        ack  [3];
    logic        err  [3];
    logic [31:0] rdat [3];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        wb_slave_ram_if bus ();
        assign bus.wbs_cyc_i = cyc[g];
        assign bus.wbs_stb_i = stb[g];
        assign bus.wbs_we_i  = we[g];
        assign bus.wbs_adr_i = adr[g];
        assign bus.wbs_dat_i = wdat[g];
        assign bus.wbs_sel_i = sel[g];
        assign ack[g]        = bus.wbs_ack_o;
        assign err[g]        = bus.wbs_err_o;
        assign rdat[g]       = bus.wbs_dat_o;
        wb_slave_ram #(
            .DEPTH_WORDS (1024),
            .WAIT_STATES (WS),
            .BASE_ADDR   (32'h0000_0000)
        ) u_dut (
            .wb_clk_i   (clk),
            .wb_rst_n_i (rst_n),
            .wbs        (bus)
        );
    end

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus(input int k);
        cyc[k]  = 1'b0;
        stb[k]  = 1'b0;
        we[k]   = 1'b0;
        adr[k]  = '0;
        wdat[k] = '0;
        sel[k]  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: latency, termination kind, read data, and a
    // quiet cycle after the response.
    task automatic xfer(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input string tag);
        int   c;
        logic seen;
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w;
        adr[k] = a;    wdat[k] = d;   sel[k] = s;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 20) begin
            tick();
            c++;
            seen = ack[k] | err[k];
        end
        check({tag, "/resp"}, 32'(seen), 32'd1);
        check({tag, "/lat"},  32'(c), 32'(1 + ws_of(k)));
        check({tag, "/ack"},  32'(ack[k]), 32'(!exp_err));
        check({tag, "/err"},  32'(err[k]), 32'(exp_err));
        if (!w) check({tag, "/data"}, rdat[k], exp_rd);
        idle_bus(k);
        tick();
        check({tag, "/width"}, {30'd0, ack[k], err[k]}, 32'd0);
    endtask

    initial begin
        logic any_resp;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) idle_bus(k);
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d/ack", k), 32'(ack[k]), 32'd0);
            check($sformatf("rst%0d/err", k), 32'(err[k]), 32'd0);
            check($sformatf("rst%0d/dat", k), rdat[k], 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic write/read with one wait state.
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, "ws1_wr10");
        xfer(0, 1'b0, 32'h10, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF, "ws1_rd10");

        // Byte lanes, empty select, ignored low address bits.
        xfer(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 32'h0, "ws1_pre20");
        xfer(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0, "ws1_lane20");
        xfer(0, 1'b0, 32'h20, 32'h0,         4'h1, 1'b0, 32'h11BB_33DD, "ws1_rd20");
        xfer(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0, "ws1_sel0");
        xfer(0, 1'b0, 32'h23, 32'h0,         4'h0, 1'b0, 32'h11BB_33DD, "ws1_rd23");

        // Out of range: 0x1000 aliases word 0 by index but must not touch it.
        xfer(0, 1'b1, 32'h0,    32'h600D_F00D, 4'hF, 1'b0, 32'h0, "ws1_wr0");
        xfer(0, 1'b0, 32'h1000, 32'h0,         4'hF, 1'b1, 32'h0, "ws1_rd1000");
        xfer(0, 1'b1, 32'h1000, 32'h0000_0BAD, 4'hF, 1'b1, 32'h0, "ws1_wr1000");
        xfer(0, 1'b0, 32'h0,    32'h0,         4'hF, 1'b0, 32'h600D_F00D, "ws1_rd0");
        xfer(0, 1'b1, 32'h4,    32'h1234_0000, 4'hF, 1'b0, 32'h0, "ws1_wr4");
        check("ws1_hold", rdat[0], 32'h600D_F00D);

        // Three wait states; cyc dropped in WAIT aborts the write.
        xfer(1, 1'b1, 32'h8, 32'h1234_5678, 4'hF, 1'b0, 32'h0, "ws3_pre8");
        xfer(1, 1'b0, 32'h8, 32'h0,         4'hF, 1'b0, 32'h1234_5678, "ws3_rd8");
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        adr[1] = 32'h8; wdat[1] = 32'h5; sel[1] = 4'hF;
        any_resp = 1'b0;
        tick();
        any_resp |= ack[1] | err[1];
        tick();
        any_resp |= ack[1] | err[1];
        idle_bus(1);
        repeat (6) begin
            tick();
            any_resp |= ack[1] | err[1];
        end
        check("ws3_abort/resp", 32'(any_resp), 32'd0);
        xfer(1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'h1234_5678, "ws3_abort_rd");

        // Zero wait states, back-to-back reads.
        xfer(2, 1'b1, 32'h0, 32'h0A0A_0A0A, 4'hF, 1'b0, 32'h0, "ws0_wr0");
        xfer(2, 1'b1, 32'h4, 32'h0B0B_0B0B, 4'hF, 1'b0, 32'h0, "ws0_wr4");
        xfer(2, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h0A0A_0A0A, "ws0_rd0");
        xfer(2, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h0B0B_0B0B, "ws0_rd4");

        // Reset in the middle of a waited write.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        adr[1] = 32'h8; wdat[1] = 32'h0000_CAFE; sel[1] = 4'hF;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid/ack", 32'(ack[1]), 32'd0);
        check("rst_mid/err", 32'(err[1]), 32'd0);
        check("rst_mid/dat", rdat[1], 32'd0);
        idle_bus(1);
        tick();
        rst_n = 1'b1;
        tick();
        xfer(1, 1'b0, 32'h8, 32'h0,         4'hF, 1'b0, 32'h1234_5678, "rst_rd8");
        xfer(1, 1'b1, 32'h8, 32'h0000_CAFE, 4'hF, 1'b0, 32'h0, "rst_wr8");
        xfer(1, 1'b0, 32'h8, 32'h0,         4'hF, 1'b0, 32'h0000_CAFE, "rst_rd8b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_slave_ram.md
WB_SLAVE_RAM -- requirements
Module: wb_slave_ram

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit words; it SHALL be a power of two and at least 4.
REQ-002 Parameter WAIT_STATES, default 1, SHALL set the extra cycles inserted before ack; legal range 0..15.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte base address; it SHALL be aligned to DEPTH_WORDS*4.
REQ-004 wb_clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 wb_rst_n_i  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 wbs_adr_i  input  32  SHALL be the byte address from the Wishbone master.
REQ-007 wbs_dat_i  input  32  SHALL be the write data.
REQ-008 wbs_dat_o  output  32  SHALL be the read data.
REQ-009 wbs_we_i  input  1  SHALL select write (1) or read (0).
REQ-010 wbs_sel_i  input  4  SHALL be the byte enables; bit n SHALL select bits 8n+7..8n.
REQ-011 wbs_stb_i  input  1  SHALL be the strobe.
REQ-012 wbs_cyc_i  input  1  SHALL mark a bus cycle in progress.
REQ-013 wbs_ack_o  output  1  SHALL be the normal termination.
REQ-014 wbs_err_o  output  1  SHALL be the error termination for out-of-range addresses.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP, each with a single defined encoding; any unused encoding SHALL return to IDLE.
REQ-016 IDLE: cyc&stb sampled high -> latch adr/dat/we/sel, compute in_range = (adr-BASE_ADDR) < DEPTH_WORDS*4, load wait counter with WAIT_STATES, go to WAIT if WAIT_STATES>0, else go to RESP.
REQ-017 WAIT: decrement counter each cycle; go to RESP on the cycle the counter reaches 1.
REQ-018 RESP: for exactly one cycle, drive ack_o=1 if in_range, else err_o=1; then return to IDLE unconditionally.
REQ-019 Latency: ack_o/err_o SHALL be high in cycle N+1+WAIT_STATES, where N is the cycle in which cyc&stb is first sampled in IDLE.
REQ-020 ack_o and err_o SHALL never be high together, and SHALL never be high for two consecutive cycles.
REQ-021 Write: at the RESP edge, only lanes with sel=1 SHALL be updated; sel=4'b0000 SHALL update nothing and SHALL still be acked.
REQ-022 Read: wbs_dat_o SHALL hold the full addressed word, independent of sel, while ack_o=1; otherwise it SHALL hold its last value.
REQ-023 Out-of-range write SHALL modify no memory; out-of-range read SHALL drive wbs_dat_o=0 with err_o.
REQ-024 Word index SHALL be adr[log2(DEPTH_WORDS)+1:2]; adr[1:0] SHALL be ignored.
REQ-025 If cyc_i drops while in WAIT, the FSM SHALL abort to IDLE next cycle without writing and without ack/err.
REQ-026 Inputs sampled during WAIT/RESP SHALL NOT alter the latched request; a new request SHALL be accepted only from IDLE.

Reset
REQ-027 Asserting wb_rst_n_i low SHALL immediately force state=IDLE, ack_o=0, err_o=0, wbs_dat_o=0, and the wait counter to 0, even in mid-transaction.
REQ-028 Memory contents SHALL NOT be cleared by reset; a transaction interrupted by reset SHALL NOT write.

Structure
REQ-029 Shared package wb_pkg SHALL hold the FSM state typedef, WB_DW=32, WB_SELW=4, and the wait-counter width constant.
REQ-030 Sub-module wb_ram_core SHALL implement a synchronous single-port RAM with byte-enabled write and registered read; wb_slave_ram SHALL contain the FSM and the range/ack logic.

Verification
REQ-031 WAIT_STATES=1, write 0xDEADBEEF to 0x10 with sel=F, then read 0x10 -> ack_o in cycle N+2 each time; read data = 0xDEADBEEF.
REQ-032 Pre-load 0x11223344 at 0x20, write 0xAABBCCDD with sel=4'b0101, then read -> 0x11BB33DD.
REQ-033 DEPTH_WORDS=1024, read 0x1000 -> err_o=1 for one cycle, ack_o=0, dat_o=0; a write to 0x1000 leaves word 0 unchanged.
REQ-034 WAIT_STATES=3, drop cyc_i after 2 cycles of a write of 0x5 to 0x8 -> no ack/err, and word 0x8 keeps its old value.
REQ-035 WAIT_STATES=0, back-to-back reads of 0x0 and 0x4 (stb dropped for one cycle after each ack) -> each ack arrives in cycle N+1 and is exactly one cycle wide.
REQ-036 Assert reset during WAIT of a write -> outputs go to 0 immediately, the target word is unchanged, and the next request completes normally.
